// File: rtl/rvx_bus_arbiter_if.sv
// Bus port bundle shared by the arbiter's manager-facing ports and its downstream port.
// "slave" is the arbiter's view of a manager; "master" is the arbiter's view of rvx_bus.
interface rvx_bus_arbiter_if;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;
    logic        error;

    modport master (
        output rw_address, write_data, write_strobe, read_request, write_request,
        input  read_data, read_response, write_response
    );

    modport slave (
        input  rw_address, write_data, write_strobe, read_request, write_request,
        output read_data, read_response, write_response, error
    );
endinterface

// File: rtl/rvx_bus_arbiter.sv
// Purpose: round-robin arbiter letting two managers share rvx_bus, one transaction at a time.
// Latency: grant registered (s_ requests one cycle after the request); responses routed combinationally.
// Backpressure: losing manager holds its request until granted; optional watchdog via RVX_BUS_ARBITER_TIMEOUT_EN.
module rvx_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    rvx_bus_arbiter_if.slave    m0,
    rvx_bus_arbiter_if.slave    m1,
    rvx_bus_arbiter_if.master   s
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;

    logic want0, want1, dev_resp;
    logic sel0, sel1;
    logic wdog_last, timeout;

    assign want0    = m0.read_request | m0.write_request;
    assign want1    = m1.read_request | m1.write_request;
    assign dev_resp = s.read_response | s.write_response;

    // Reset gates the grant so every output is quiet while reset is held.
    assign sel0 = ~reset && (state == BUSY0);
    assign sel1 = ~reset && (state == BUSY1);

`ifdef RVX_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog;

    assign wdog_last = (sel0 | sel1) && (wdog == WDOG_LAST);
    assign timeout   = wdog_last & ~dev_resp;

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog <= '0;
        end else if (state == IDLE) begin
            wdog <= '0;
        end else if (!dev_resp) begin
            wdog <= wdog + 16'd1;
        end
    end
`else
    assign wdog_last = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                // On a tie the manager that did not win last time is served.
                if (want0 && (!want1 || last_grant)) begin
                    state_nxt      = BUSY0;
                    last_grant_nxt = 1'b0;
                end else if (want1) begin
                    state_nxt      = BUSY1;
                    last_grant_nxt = 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                if (dev_resp || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.rw_address    = sel0 ? m0.rw_address   : (sel1 ? m1.rw_address   : 32'h0);
        s.write_data    = sel0 ? m0.write_data   : (sel1 ? m1.write_data   : 32'h0);
        s.write_strobe  = sel0 ? m0.write_strobe : (sel1 ? m1.write_strobe : 4'h0);
        s.read_request  = ((sel0 & m0.read_request)  | (sel1 & m1.read_request))  & ~wdog_last;
        s.write_request = ((sel0 & m0.write_request) | (sel1 & m1.write_request)) & ~wdog_last;
    end

    always_comb begin
        m0.read_response  = sel0 & (s.read_response  | (timeout & m0.read_request));
        m0.write_response = sel0 & (s.write_response | (timeout & m0.write_request));
        m0.error          = sel0 & timeout;
        m0.read_data      = 32'h0;
        if (sel0 && s.read_response) begin
            m0.read_data = s.read_data;
        end else if (sel0 && timeout && m0.read_request) begin
            m0.read_data = 32'hDEADBEEF;
        end

        m1.read_response  = sel1 & (s.read_response  | (timeout & m1.read_request));
        m1.write_response = sel1 & (s.write_response | (timeout & m1.write_request));
        m1.error          = sel1 & timeout;
        m1.read_data      = 32'h0;
        if (sel1 && s.read_response) begin
            m1.read_data = s.read_data;
        end else if (sel1 && timeout && m1.read_request) begin
            m1.read_data = 32'hDEADBEEF;
        end
    end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Cycle-by-cycle vector bench for rvx_bus_arbiter; watchdog rows are added when RVX_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_rvx_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0020;
    localparam logic [31:0] D0 = 32'hA0A0_A0A0;
    localparam logic [31:0] D1 = 32'hB1B1_B1B1;
    localparam logic [3:0]  S0 = 4'h3;
    localparam logic [3:0]  S1 = 4'hC;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rvx_bus_arbiter_if m0_if ();
    rvx_bus_arbiter_if m1_if ();
    rvx_bus_arbiter_if s_if ();

    rvx_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    // Request/response pairs are {read, write}; gnt is 0 none, 1 m0, 2 m1.
    typedef struct {
        bit          rst;
        bit [1:0]    m0_req;
        bit [1:0]    m1_req;
        bit [1:0]    s_resp;
        logic [31:0] s_rdata;
        bit [1:0]    gnt;
        bit [1:0]    s_req;
        bit [1:0]    m0_resp;
        bit [1:0]    m1_resp;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit rst, input bit [1:0] m0r, input bit [1:0] m1r,
                       input bit [1:0] sr, input logic [31:0] srd,
                       input bit [1:0] g, input bit [1:0] sq,
                       input bit [1:0] r0, input bit [1:0] r1,
                       input logic [31:0] rd, input bit err);
        vec_t v;
        v.rst = rst; v.m0_req = m0r; v.m1_req = m1r; v.s_resp = sr; v.s_rdata = srd;
        v.gnt = g; v.s_req = sq; v.m0_resp = r0; v.m1_resp = r1; v.rdata = rd; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        logic [79:0] exp_s, exp_m0, exp_m1;
        logic [31:0] ea, ed;
        logic [3:0]  es;

        // reset, then m0 read with two device wait cycles
        add(1, 2'b00, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(1, 2'b00, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 1, 2'b10, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 1, 2'b10, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b10, 32'h1234_5678, 1, 2'b10, 2'b10, 2'b00, 32'h1234_5678, 0);
        add(0, 2'b00, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        // stray response in IDLE is dropped
        add(0, 2'b00, 2'b00, 2'b10, 32'hFFFF_FFFF, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        // re-reset, both write continuously: m0, m1, m0 with an IDLE between grants
        add(1, 2'b00, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b01, 2'b01, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b01, 2'b01, 2'b01, 32'h0, 1, 2'b01, 2'b01, 2'b00, 32'h0, 0);
        add(0, 2'b01, 2'b01, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b01, 2'b01, 2'b01, 32'h0, 2, 2'b01, 2'b00, 2'b01, 32'h0, 0);
        add(0, 2'b01, 2'b01, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b01, 2'b01, 2'b01, 32'h0, 1, 2'b01, 2'b01, 2'b00, 32'h0, 0);
        // m1 write in flight while m0 asks to read
        add(0, 2'b00, 2'b01, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b01, 2'b00, 32'h0, 2, 2'b01, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b01, 2'b01, 32'h0, 2, 2'b01, 2'b00, 2'b01, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 1, 2'b10, 2'b00, 2'b00, 32'h0, 0);
        // m0 drops its request but keeps the grant until the response
        add(0, 2'b00, 2'b01, 2'b00, 32'h0, 1, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b00, 2'b01, 2'b10, 32'hCAFE_F00D, 1, 2'b00, 2'b10, 2'b00, 32'hCAFE_F00D, 0);
        add(0, 2'b00, 2'b01, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b00, 2'b01, 2'b00, 32'h0, 2, 2'b01, 2'b00, 2'b00, 32'h0, 0);
        // reset during m1 BUSY, late device response dropped, m1 regranted
        add(1, 2'b00, 2'b01, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b00, 2'b01, 2'b01, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b00, 2'b01, 2'b01, 32'h0, 2, 2'b01, 2'b00, 2'b01, 32'h0, 0);
        add(0, 2'b00, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
`ifdef RVX_BUS_ARBITER_TIMEOUT_EN
        // silent device: watchdog fires in the 8th BUSY cycle
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        for (int k = 0; k < 7; k++)
            add(0, 2'b10, 2'b00, 2'b00, 32'h0, 1, 2'b10, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 1, 2'b00, 2'b10, 2'b00, 32'hDEAD_BEEF, 1);
        // device answers in the watchdog's final cycle: real data, no error
        add(0, 2'b10, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
        for (int k = 0; k < 7; k++)
            add(0, 2'b10, 2'b00, 2'b00, 32'h0, 1, 2'b10, 2'b00, 2'b00, 32'h0, 0);
        add(0, 2'b10, 2'b00, 2'b10, 32'h55AA_55AA, 1, 2'b00, 2'b10, 2'b00, 32'h55AA_55AA, 0);
        add(0, 2'b00, 2'b00, 2'b00, 32'h0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 0);
`endif

        m0_if.rw_address = A0; m0_if.write_data = D0; m0_if.write_strobe = S0;
        m1_if.rw_address = A1; m1_if.write_data = D1; m1_if.write_strobe = S1;
        s_if.error = 1'b0;

        foreach (vecs[i]) begin
            reset                = vecs[i].rst;
            m0_if.read_request   = vecs[i].m0_req[1];
            m0_if.write_request  = vecs[i].m0_req[0];
            m1_if.read_request   = vecs[i].m1_req[1];
            m1_if.write_request  = vecs[i].m1_req[0];
            s_if.read_response   = vecs[i].s_resp[1];
            s_if.write_response  = vecs[i].s_resp[0];
            s_if.read_data       = vecs[i].s_rdata;
            @(negedge clock);

            ea = (vecs[i].gnt == 1) ? A0 : (vecs[i].gnt == 2) ? A1 : 32'h0;
            ed = (vecs[i].gnt == 1) ? D0 : (vecs[i].gnt == 2) ? D1 : 32'h0;
            es = (vecs[i].gnt == 1) ? S0 : (vecs[i].gnt == 2) ? S1 : 4'h0;
            exp_s  = {10'h0, vecs[i].s_req, ea, ed, es};
            exp_m0 = {45'h0, vecs[i].m0_resp, (vecs[i].gnt == 1) && vecs[i].err,
                      vecs[i].m0_resp[1] ? vecs[i].rdata : 32'h0};
            exp_m1 = {45'h0, vecs[i].m1_resp, (vecs[i].gnt == 2) && vecs[i].err,
                      vecs[i].m1_resp[1] ? vecs[i].rdata : 32'h0};

            check("s_bus", i, {10'h0, s_if.read_request, s_if.write_request, s_if.rw_address,
                               s_if.write_data, s_if.write_strobe}, exp_s);
            check("m0_rsp", i, {45'h0, m0_if.read_response, m0_if.write_response, m0_if.error,
                                m0_if.read_data}, exp_m0);
            check("m1_rsp", i, {45'h0, m1_if.read_response, m1_if.write_response, m1_if.error,
                                m1_if.read_data}, exp_m1);

            @(posedge clock);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
